// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the mux_arb_4 arbiter slice.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_4to1.sv
// Single-bit 4:1 mux used on the shared output path.
module mux_4to1
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_data,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_data
);

    assign o_data = i_data[i_sel];

endmodule

// File: rtl/mux_arb_4.sv
// Round-robin arbiter that owns the shared 4:1 mux path and drives its select.
// Define MUX_ARB_HOLD_LIMIT_EN to force a handover after MAX_HOLD granted cycles.
module mux_arb_4
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             data_out
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_arb_4: MAX_HOLD must be in 1..255");
    end

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_valid, w_valid_nxt;
    logic [SEL_W-1:0] w_arb_ptr, w_pick_idx;
    logic             w_pick_found;
    logic             w_owner_req, w_limit_hit, w_rearb;
    logic             w_mux_bit;

    // First set bit scanning upward from ptr with wrap; MSB of the result flags a hit.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        rr_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign w_owner_req = req[r_sel];
    assign w_rearb     = (r_state == OWN) && (!w_owner_req || w_limit_hit);
    // A releasing or expiring owner moves the pointer past itself before the new pick.
    assign w_arb_ptr   = (r_state == OWN) ? r_sel + 1'b1 : r_ptr;
    assign {w_pick_found, w_pick_idx} = rr_pick(req, w_arb_ptr);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    // r_cnt is one less than the cycles granted so far, so the limit trips at MAX_HOLD-1.
    assign w_limit_hit = w_owner_req && (r_cnt >= CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == IDLE || w_rearb)
            w_cnt_nxt = '0;
        else if (r_cnt != CNT_W'(MAX_HOLD))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_nxt;
    end
`else
    assign w_limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        // NOTE: every target defaults to its held value first, so no latch is inferred.
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = OWN;
                    w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
                    w_sel_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
                end
            end
            OWN: begin
                if (w_rearb) begin
                    w_ptr_nxt = w_arb_ptr;
                    if (w_pick_found) begin
                        w_gnt_nxt = N_REQ'(1) << w_pick_idx;
                        w_sel_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
        endcase
    end

    mux_4to1 u_mux (
        .i_data (data_in),
        .i_sel  (r_sel),
        .o_data (w_mux_bit)
    );

    always_comb begin
        data_out = r_valid & w_mux_bit;
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;

endmodule

// File: tb/tb_mux_arb_4.sv
// Self-checking bench for mux_arb_4: directed vector table, hold-limit and
// async-reset sequences, then random traffic against a behavioural model.
module tb_mux_arb_4;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam int TB_MAX_HOLD = 3;
    localparam bit HOLD_EN     = 1'b1;
`else
    localparam int TB_MAX_HOLD = 8;
    localparam bit HOLD_EN     = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] req_i  = '0;
    logic [3:0] data_i = '0;
    logic [3:0] gnt_o;
    logic [1:0] sel_o;
    logic       valid_o;
    logic       dout_o;

    always #5 clk = ~clk;

    mux_arb_4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req_i),
        .data_in  (data_i),
        .gnt      (gnt_o),
        .sel      (sel_o),
        .valid    (valid_o),
        .data_out (dout_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: owner index (-1 when idle), rotate start, cycles held.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_held;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       dout;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                                 input logic e_valid, input logic e_dout);
        check($sformatf("%s.gnt", tag),      32'(gnt_o),   32'(e_gnt));
        check($sformatf("%s.sel", tag),      32'(sel_o),   32'(e_sel));
        check($sformatf("%s.valid", tag),    32'(valid_o), 32'(e_valid));
        check($sformatf("%s.data_out", tag), 32'(dout_o),  32'(e_dout));
    endtask

    function automatic int ref_pick(input logic [3:0] r, input int start);
        for (int off = 0; off < 4; off++) begin
            if (r[(start + off) % 4]) return (start + off) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_held  = 0;
    endtask

    task automatic model_update(input logic [3:0] r);
        int p;
        if (m_owner < 0) begin
            p = ref_pick(r, m_ptr);
            if (p >= 0) begin
                m_owner = p;
                m_sel   = p;
                m_held  = 1;
            end
        end else if (!r[m_owner] || (HOLD_EN && m_held >= TB_MAX_HOLD)) begin
            m_ptr   = (m_owner + 1) % 4;
            p       = ref_pick(r, m_ptr);
            m_owner = p;
            if (p >= 0) begin
                m_sel  = p;
                m_held = 1;
            end
        end else begin
            m_held++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] e_gnt;
        logic       e_valid;
        e_gnt   = '0;
        e_valid = (m_owner >= 0);
        if (e_valid) e_gnt[m_owner] = 1'b1;
        check_outputs(tag, e_gnt, 2'(m_sel), e_valid, e_valid & data_i[m_sel]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[1]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[3]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[4]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[5]  = '{4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[6]  = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[7]  = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[8]  = '{4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[9]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[10] = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[11] = '{4'b1110, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[12] = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[13] = '{4'b1101, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[14] = '{4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[15] = '{4'b1011, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[16] = '{4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[17] = '{4'b0111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[18] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};

        // Reset held with every request and data bit high.
        rst    = 1'b1;
        req_i  = 4'b1111;
        data_i = 4'b1111;
        repeat (2) tick();
        check_outputs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_i  = 4'b0000;
        rst    = 1'b0;
        model_reset();

        // Directed table: single requester, direct handover, full round robin.
        for (int i = 0; i < 19; i++) begin
            req_i  = vecs[i].req;
            data_i = vecs[i].data;
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].dout);
        end

        // Two requesters held constant: rotation only when the hold limit exists.
        do_reset();
        req_i  = 4'b0011;
        data_i = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (HOLD_EN && ((k / 3) % 2 == 1))
                check_outputs($sformatf("hold_pair%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
            else
                check_outputs($sformatf("hold_pair%0d", k), 4'b0001, 2'd0, 1'b1, 1'b1);
        end
        req_i = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outputs($sformatf("hold_solo%0d", k), 4'b0001, 2'd0, 1'b1, 1'b1);
        end

        // Asynchronous reset mid-grant must clear outputs before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        model_reset();

        // Random traffic: requests toggle one bit at a time so owners hold for a while.
        req_i = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            int b;
            if ($urandom_range(0, 2) == 0) begin
                b        = $urandom_range(0, 3);
                req_i[b] = ~req_i[b];
            end
            data_i = 4'($urandom);
            @(posedge clk);
            model_update(req_i);
            #1;
            check_model($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
